// File: rtl/rob_pkg.sv
// Shared types for the ROB commit controller: the ROB entry layout, the commit FSM
// states and the sizing constants the commit logic is built around.
package rob_pkg;

   localparam int ROB_ENTRIES   = 32;
   localparam int INSTR_Q_WIDTH = 4;
   localparam int SIZE_W        = $clog2(ROB_ENTRIES);
   localparam int ROB_ADDR_W    = 64;

   typedef struct packed {
      logic                  done;
      logic                  exc;
      logic                  mispred;
      logic [ROB_ADDR_W-1:0] pc;
      logic [ROB_ADDR_W-1:0] target;
   } rob_entry;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      REDIRECT
   } commit_state_e;

   // A lane retires silently only when it has finished and raised nothing.
   function automatic logic lane_clean(input rob_entry e);
      return e.done & ~e.exc & ~e.mispred;
   endfunction

endpackage

// File: rtl/rob_commit_scan.sv
// Combinational priority scan over the oldest ROB lanes: counts the leading clean
// lanes and reports the first finished lane that carries an exception or mispredict.
module rob_commit_scan
   import rob_pkg::*;
#(
   parameter  int COMMIT_WIDTH = 4,
   localparam int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
   input  rob_entry                i_head [COMMIT_WIDTH],
   input  logic [SIZE_W-1:0]       i_size,
   output logic [CNT_W-1:0]        o_clean_cnt,
   output logic                    o_stop_vld,
   output logic                    o_stop_exc,
   output logic [ROB_ADDR_W-1:0]   o_stop_target
);

   logic w_blocked;
   logic w_unused_pc;

   always_comb begin
      o_clean_cnt   = '0;
      o_stop_vld    = 1'b0;
      o_stop_exc    = 1'b0;
      o_stop_target = '0;
      w_blocked     = 1'b0;
      w_unused_pc   = 1'b0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         w_unused_pc = w_unused_pc ^ (^i_head[i].pc);
         if (!w_blocked) begin
            // A lane beyond occupancy or still executing shadows every younger lane.
            if ((i < int'(i_size)) && i_head[i].done) begin
               if (i_head[i].exc) begin
                  o_stop_vld = 1'b1;
                  o_stop_exc = 1'b1;
                  w_blocked  = 1'b1;
               end else if (i_head[i].mispred) begin
                  o_stop_vld    = 1'b1;
                  o_stop_target = i_head[i].target;
                  w_blocked     = 1'b1;
               end else if (lane_clean(i_head[i])) begin
                  o_clean_cnt = o_clean_cnt + CNT_W'(1);
               end
            end else begin
               w_blocked = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB commit controller: retires up to COMMIT_WIDTH oldest entries per cycle and sequences
// RUN -> FLUSH -> REDIRECT on exception/mispredict. Optional counters: ROB_COMMIT_PERF_EN.
module rob_commit_ctrl
   import rob_pkg::*;
#(
   parameter  int                   COMMIT_WIDTH = 4,
   parameter  int                   ADDR_BITS    = 64,
   parameter  logic [ADDR_BITS-1:0] EXC_VECTOR   = '0,
   localparam int                   CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
   input  logic                    clk_in,
   input  logic                    rst_N_in,
   input  rob_entry                head_in [COMMIT_WIDTH],
   input  logic [SIZE_W-1:0]       size_in,
   output logic [CNT_W-1:0]        deq_out,
   output logic [COMMIT_WIDTH-1:0] commit_mask_out,
   output logic                    flush_out,
   output logic                    valid_pc,
   output logic [ADDR_BITS-1:0]    pc_out
`ifdef ROB_COMMIT_PERF_EN
   ,
   output logic [63:0]             retired_cnt_out,
   output logic [63:0]             flush_cnt_out
`endif
);

   commit_state_e           r_state;
   logic [ADDR_BITS-1:0]    r_pc_t;
   logic                    r_flush;
   logic                    r_valid_pc;
   logic [ADDR_BITS-1:0]    r_pc_out;

   logic [CNT_W-1:0]        w_clean_cnt;
   logic                    w_stop_vld;
   logic                    w_stop_exc;
   logic [ROB_ADDR_W-1:0]   w_stop_target;
   logic [CNT_W-1:0]        w_deq;
   logic                    w_take_flush;

   rob_commit_scan #(
      .COMMIT_WIDTH (COMMIT_WIDTH)
   ) u_scan (
      .i_head        (head_in),
      .i_size        (size_in),
      .o_clean_cnt   (w_clean_cnt),
      .o_stop_vld    (w_stop_vld),
      .o_stop_exc    (w_stop_exc),
      .o_stop_target (w_stop_target)
   );

   assign w_take_flush = rst_N_in && (r_state == RUN) && w_stop_vld;

   // Retirement is same-cycle; a mispredicted branch itself retires, a faulting one does not.
   always_comb begin
      w_deq           = '0;
      commit_mask_out = '0;
      if (rst_N_in && (r_state == RUN)) begin
         if (w_stop_vld && !w_stop_exc) begin
            w_deq = w_clean_cnt + CNT_W'(1);
         end else begin
            w_deq = w_clean_cnt;
         end
      end
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         commit_mask_out[i] = (i < int'(w_deq));
      end
   end

   assign deq_out = w_deq;

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         r_state    <= RUN;
         r_pc_t     <= '0;
         r_flush    <= 1'b0;
         r_valid_pc <= 1'b0;
         r_pc_out   <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_stop_vld) begin
                  r_state <= FLUSH;
                  r_flush <= 1'b1;
                  r_pc_t  <= w_stop_exc ? EXC_VECTOR : w_stop_target[ADDR_BITS-1:0];
               end
            end
            FLUSH: begin
               r_state    <= REDIRECT;
               r_flush    <= 1'b0;
               r_valid_pc <= 1'b1;
               r_pc_out   <= r_pc_t;
            end
            REDIRECT: begin
               r_state    <= RUN;
               r_valid_pc <= 1'b0;
               r_pc_out   <= '0;
            end
            default: begin
               r_state    <= RUN;
               r_flush    <= 1'b0;
               r_valid_pc <= 1'b0;
               r_pc_out   <= '0;
            end
         endcase
      end
   end

   assign flush_out = r_flush;
   assign valid_pc  = r_valid_pc;
   assign pc_out    = r_pc_out;

`ifdef ROB_COMMIT_PERF_EN
   logic [63:0] r_retired_cnt;
   logic [63:0] r_flush_cnt;

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         r_retired_cnt <= '0;
         r_flush_cnt   <= '0;
      end else begin
         r_retired_cnt <= r_retired_cnt + 64'(w_deq);
         if (w_take_flush) begin
            r_flush_cnt <= r_flush_cnt + 64'd1;
         end
      end
   end

   assign retired_cnt_out = r_retired_cnt;
   assign flush_cnt_out   = r_flush_cnt;
`else
   logic w_unused_take_flush;
   assign w_unused_take_flush = w_take_flush;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Scoreboard bench for rob_commit_ctrl: expected outputs are queued as stimulus is driven
// and compared against the sampled DUT outputs, scenario by scenario.
module tb_rob_commit_ctrl;
   import rob_pkg::*;

   localparam int          CW  = 4;
   localparam logic [63:0] EXC = 64'h0000_0000_8000_0100;

   typedef logic [72:0] obs_t;   // {deq[2:0], mask[3:0], flush, valid_pc, pc[63:0]}

   logic              clk = 1'b0;
   logic              rst_n;
   rob_entry          head [CW];
   logic [SIZE_W-1:0] size;
   logic [2:0]        deq;
   logic [3:0]        mask;
   logic              flush;
   logic              vpc;
   logic [63:0]       pc;
`ifdef ROB_COMMIT_PERF_EN
   logic [63:0]       retired_cnt;
   logic [63:0]       flush_cnt;
`endif

   obs_t exp_q[$];
   obs_t obs_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // reference model state for the randomized run
   int          m_state = 0;
   logic [63:0] m_pc_t  = '0;

   always #5 clk = ~clk;

   rob_commit_ctrl #(
      .COMMIT_WIDTH (CW),
      .ADDR_BITS    (64),
      .EXC_VECTOR   (EXC)
   ) dut (
      .clk_in          (clk),
      .rst_N_in        (rst_n),
      .head_in         (head),
      .size_in         (size),
      .deq_out         (deq),
      .commit_mask_out (mask),
      .flush_out       (flush),
      .valid_pc        (vpc),
      .pc_out          (pc)
`ifdef ROB_COMMIT_PERF_EN
      ,
      .retired_cnt_out (retired_cnt),
      .flush_cnt_out   (flush_cnt)
`endif
   );

   function automatic obs_t mk(int d, int m, bit f, bit v, logic [63:0] p);
      return {3'(d), 4'(m), f, v, p};
   endfunction

   function automatic obs_t cur();
      return {deq, mask, flush, vpc, pc};
   endfunction

   function automatic rob_entry ent(bit d, bit e, bit mp, logic [63:0] tgt);
      rob_entry r;
      r.done    = d;
      r.exc     = e;
      r.mispred = mp;
      r.pc      = 64'h1000;
      r.target  = tgt;
      return r;
   endfunction

   task automatic set_all(bit d, bit e, bit mp, logic [63:0] tgt);
      for (int i = 0; i < CW; i++) head[i] = ent(d, e, mp, tgt);
   endtask

   // Sample on the falling edge, then advance to just after the next rising edge.
   task automatic step();
      @(negedge clk);
      obs_q.push_back(cur());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t e, o;
      rst_n = 1'b0;
      set_all(1, 0, 0, 64'h0);
      size = 5'd4;
      #3;
      obs_q.push_back(cur());
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      rst_n = 1'b1;
      exp_q.push_back(mk(4, 4'b1111, 0, 0, 0));
      step();
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_all_clean_and_not_done();
      obs_t e, o;
      set_all(1, 0, 0, 64'h0);
      size = 5'd4;
      exp_q.push_back(mk(4, 4'b1111, 0, 0, 0));
      step();
      head[2].done = 1'b0;
      exp_q.push_back(mk(2, 4'b0011, 0, 0, 0));
      step();
      exp_q.push_back(mk(2, 4'b0011, 0, 0, 0));
      step();
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL clean/not_done: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_mispred();
      obs_t e, o;
      set_all(1, 0, 0, 64'h0);
      head[1] = ent(1, 0, 1, 64'h4000);
      size = 5'd4;
      exp_q.push_back(mk(2, 4'b0011, 0, 0, 0));
      step();
      // inputs that would retire or flush again must be ignored now
      set_all(1, 0, 1, 64'h9999);
      exp_q.push_back(mk(0, 0, 1, 0, 0));
      step();
      exp_q.push_back(mk(0, 0, 0, 1, 64'h4000));
      step();
      set_all(1, 0, 0, 64'h0);
      exp_q.push_back(mk(4, 4'b1111, 0, 0, 0));
      step();
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL mispred: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_exc();
      obs_t e, o;
      set_all(1, 0, 0, 64'h0);
      head[0] = ent(1, 1, 1, 64'h1234);
      size = 5'd4;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      exp_q.push_back(mk(0, 0, 1, 0, 0));
      step();
      exp_q.push_back(mk(0, 0, 0, 1, EXC));
      step();
      set_all(1, 0, 0, 64'h0);
      size = 5'd3;
      exp_q.push_back(mk(3, 4'b0111, 0, 0, 0));
      step();
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL exc: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_size_limit();
      obs_t e, o;
      set_all(1, 0, 0, 64'h0);
      size = 5'd1;
      exp_q.push_back(mk(1, 4'b0001, 0, 0, 0));
      step();
      size = 5'd0;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      // a mispredict just past occupancy is not visible yet
      head[1] = ent(1, 0, 1, 64'h7000);
      size = 5'd1;
      exp_q.push_back(mk(1, 4'b0001, 0, 0, 0));
      step();
      size = 5'd0;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL size_limit: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_reset_mid_flush();
      obs_t e, o;
      set_all(1, 0, 0, 64'h0);
      head[0] = ent(1, 0, 1, 64'h55);
      size = 5'd4;
      exp_q.push_back(mk(1, 4'b0001, 0, 0, 0));
      step();
      set_all(0, 0, 0, 64'h0);
      size = 5'd0;
      obs_q.push_back(cur());
      exp_q.push_back(mk(0, 0, 1, 0, 0));
      rst_n = 1'b0;
      #1;
      obs_q.push_back(cur());
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         exp_q.push_back(mk(0, 0, 0, 0, 0));
      end
      set_all(1, 0, 0, 64'h0);
      size = 5'd2;
      exp_q.push_back(mk(2, 4'b0011, 0, 0, 0));
      step();
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_flush: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, o;
      int   k, d, r;
      m_state = 0;
      m_pc_t  = '0;
      for (int c = 0; c < 300; c++) begin
         size = 5'($urandom_range(0, 6));
         for (int i = 0; i < CW; i++) begin
            r = $urandom_range(0, 99);
            head[i] = ent(r < 88, r >= 80 && r < 84, r >= 84 && r < 88,
                          {$urandom, $urandom});
         end
         case (m_state)
            0: begin
               k = 0;
               while (k < CW && k < int'(size) && head[k].done &&
                      !head[k].exc && !head[k].mispred) k++;
               if (k < CW && k < int'(size) && head[k].done) begin
                  d       = head[k].exc ? k : k + 1;
                  m_pc_t  = head[k].exc ? EXC : head[k].target;
                  m_state = 1;
               end else begin
                  d = k;
               end
               exp_q.push_back(mk(d, (1 << d) - 1, 0, 0, 0));
            end
            1: begin
               exp_q.push_back(mk(0, 0, 1, 0, 0));
               m_state = 2;
            end
            default: begin
               exp_q.push_back(mk(0, 0, 0, 1, m_pc_t));
               m_state = 0;
            end
         endcase
         step();
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL back_to_back: got %h required %h", o, e);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      size  = '0;
      set_all(0, 0, 0, 64'h0);
      test_reset();
      test_all_clean_and_not_done();
      test_mispred();
      test_exc();
      test_size_limit();
      test_reset_mid_flush();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
